// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES types, FIPS-197 S-box tables and the lane-count legality check
// for the time-multiplexed SubBytes engine.
package sub_bytes_engine_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  // Entry 0 sits in the top byte; entry x is at [2047-8x -: 8].
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic byte_t sbox_lookup(byte_t x, logic inv);
    logic [2047:0] t;
    logic [10:0]   hi;
    t  = inv ? SBOX_INV : SBOX_FWD;
    hi = 11'd2047 - {x, 3'b000};
    return t[hi -: 8];
  endfunction

  function automatic bit lanes_ok(int n);
    return (n == 1) || (n == 2) || (n == 4) ||
           (n == 8) || (n == 16);
  endfunction

endpackage

// File: rtl/sub_bytes_engine_sbox_lane.sv
// One combinational byte-substitution unit: forward or inverse S-box
// chosen by the mode bit.
module sbox_lane
  import sub_bytes_engine_pkg::*;
(
  input  logic [7:0] value,
  input  logic       inv,
  output logic [7:0] result
);

  assign result = sbox_lookup(value, inv);

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential SubBytes: LANES S-box units swept over the 16-byte state
// in 16/LANES beats, with valid/ready on both sides.
module sub_bytes_engine
  import sub_bytes_engine_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  state_t        data_q;
  state_t        result_q;
  logic          inv_q;
  logic          last;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  assign last = (cnt_q == CW'(BEATS - 1));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[8*(int'(cnt_q)*LANES + l) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .value  (lane_in[l]),
      .inv    (inv_q),
      .result (lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter holds at BEATS-1 so it never wraps within a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        data_q <= in_data;
        inv_q  <= in_inv;
        cnt_q  <= '0;
      end
      if (state_q == BUSY) begin
        for (int l = 0; l < LANES; l++) begin
          result_q[8*(int'(cnt_q)*LANES + l) +: 8] <= lane_out[l];
        end
        if (!last) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
